// File: rtl/text_overlay_renderer_pkg.sv
// Shared types for the title text overlay: font geometry,
// stage bundles and the built-in glyph table.
package text_pkg;

  localparam int FONT_W = 8;
  localparam int FONT_H = 16;

  typedef logic [6:0]  char_t;
  typedef logic [10:0] font_addr_t;

  typedef struct packed {
    logic       visible;
    logic [2:0] bidx;
    logic [3:0] row;
  } s1_t;

  typedef struct packed {
    logic       visible;
    logic       nonblank;
    logic [2:0] bidx;
  } s2_t;

  // Synthetic glyph set; code 0 is an empty cell.
  function automatic logic [7:0] font_glyph(font_addr_t a);
    logic [7:0] cc;
    logic [7:0] rr;
    cc = {1'b0, a[10:4]};
    rr = {4'b0, a[3:0]};
    if (a[10:4] == 7'd0) return 8'd0;
    return (cc * 8'd37 + rr * 8'd19) ^ {a[3:0], a[7:4]};
  endfunction

endpackage

// File: rtl/text_overlay_renderer_if.sv
// Scan-position, text ROM and pixel signals of the overlay.
// master: video timing / text ROM side, slave: the renderer.
interface text_overlay_renderer_if;
  import text_pkg::*;

  logic       frame_start;
  logic       restart;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [3:0] text_addr;
  char_t      text_data;
  logic       pixel_on;
  logic       reveal_done;

  modport master (
    output frame_start, restart, DrawX, DrawY, text_data,
    input  text_addr, pixel_on, reveal_done
  );

  modport slave (
    input  frame_start, restart, DrawX, DrawY, text_data,
    output text_addr, pixel_on, reveal_done
  );

endinterface

// File: rtl/font_rom_sync.sv
// 2048x8 glyph ROM, registered output, one-cycle read latency.
module font_rom_sync
  import text_pkg::*;
(
  input  logic       clk,
  input  font_addr_t addr,
  output logic [7:0] data
);

  always_ff @(posedge clk) begin
    data <= font_glyph(addr);
  end

endmodule

// File: rtl/text_overlay_renderer.sv
// Title text pixel generator: box decode, 3-stage glyph
// pipeline and frame-counted typewriter reveal.
module text_overlay_renderer
  import text_pkg::*;
#(
  parameter logic [9:0] X0              = 10'd256,
  parameter logic [9:0] Y0              = 10'd64,
  parameter int         NCHARS          = 9,
  parameter int         FRAMES_PER_CHAR = 8
) (
  input logic                     Clk,
  input logic                     Reset_n,
  text_overlay_renderer_if.slave  bus
);

  localparam logic [10:0] XEND =
    11'(X0) + 11'(FONT_W * NCHARS);
  localparam logic [10:0] YEND =
    11'(Y0) + 11'(FONT_H);
  localparam logic [4:0] NC    = 5'(NCHARS);
  localparam logic [7:0] FLAST = 8'(FRAMES_PER_CHAR - 1);

  logic       in_box;
  logic [7:0] dx8;
  logic [3:0] dy4;
  s1_t        s1_d;
  s1_t        s1_q;
  s2_t        s2_q;
  font_addr_t font_addr;
  logic [7:0] font_byte;
  logic [4:0] reveal_count;
  logic [7:0] frame_cnt;

  // Only the low offset bits matter inside the box, so the
  // subtraction is done at reduced width.
  always_comb begin
    in_box = (bus.DrawX >= X0)
          && ({1'b0, bus.DrawX} < XEND)
          && (bus.DrawY >= Y0)
          && ({1'b0, bus.DrawY} < YEND);
    dx8 = bus.DrawX[7:0] - X0[7:0];
    dy4 = bus.DrawY[3:0] - Y0[3:0];
    s1_d = '0;
    s1_d.visible = in_box && (dx8[7:3] < reveal_count);
    s1_d.bidx = dx8[2:0];
    s1_d.row = dy4;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q          <= '0;
      bus.text_addr <= '0;
    end else begin
      s1_q          <= s1_d;
      bus.text_addr <= in_box ? dx8[6:3] : 4'd0;
    end
  end

  assign font_addr = {bus.text_data, s1_q.row};

  font_rom_sync u_font (
    .clk  (Clk),
    .addr (font_addr),
    .data (font_byte)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_q <= '0;
    end else begin
      s2_q.visible  <= s1_q.visible;
      s2_q.nonblank <= |bus.text_data;
      s2_q.bidx     <= s1_q.bidx;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.pixel_on <= 1'b0;
    end else begin
      bus.pixel_on <= font_byte[3'd7 - s2_q.bidx]
                   && s2_q.visible
                   && s2_q.nonblank;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      reveal_count    <= '0;
      frame_cnt       <= '0;
      bus.reveal_done <= 1'b0;
    end else if (bus.restart) begin
      reveal_count    <= '0;
      frame_cnt       <= '0;
      bus.reveal_done <= 1'b0;
    end else if (bus.frame_start && reveal_count < NC) begin
      if (frame_cnt == FLAST) begin
        frame_cnt       <= '0;
        reveal_count    <= reveal_count + 5'd1;
        bus.reveal_done <= (reveal_count + 5'd1) == NC;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Directed/random bench for text_overlay_renderer with a
// pixel-level reference model of the text box and reveal.
module tb_text_overlay_renderer;
  import text_pkg::*;

  localparam int NCH = 9;
  localparam int FPC = 2;
  localparam int BX  = 256;
  localparam int BY  = 64;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  text_overlay_renderer_if bus ();
  char_t txt [16];
  assign bus.text_data = txt[bus.text_addr];

  text_overlay_renderer #(
    .X0              (10'd256),
    .Y0              (10'd64),
    .NCHARS          (NCH),
    .FRAMES_PER_CHAR (FPC)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_rc = 0;
  int m_fc = 0;
  int px[$];
  int py[$];
  int ea[$];
  int ep[$];

  function automatic int font_ref(int code, int r);
    if (code == 0) return 0;
    return ((code * 37 + r * 19) & 255) ^ ((r << 4) | (code & 15));
  endfunction

  function automatic bit inside_box(int x, int y);
    return x >= BX && x < BX + 8 * NCH && y >= BY && y < BY + 16;
  endfunction

  function automatic int exp_addr(int x, int y);
    return inside_box(x, y) ? (x - BX) / 8 : 0;
  endfunction

  function automatic int exp_pix(int x, int y);
    int c;
    int b;
    int r;
    if (!inside_box(x, y)) return 0;
    c = (x - BX) / 8;
    b = (x - BX) % 8;
    r = y - BY;
    if (c >= m_rc) return 0;
    return (font_ref(int'(txt[c]), r) >> (7 - b)) & 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_pt(input int x, input int y);
    px.push_back(x);
    py.push_back(y);
  endtask

  // Streams the queued points one per clock and checks
  // text_addr one cycle and pixel_on three cycles later.
  task automatic run_pts(input string tag);
    int n;
    n = px.size();
    ea.delete();
    ep.delete();
    for (int i = 0; i < n; i++) begin
      ea.push_back(exp_addr(px[i], py[i]));
      ep.push_back(exp_pix(px[i], py[i]));
    end
    for (int i = 0; i < n + 3; i++) begin
      @(posedge Clk);
      #1;
      bus.DrawX = (i < n) ? 10'(px[i]) : 10'd0;
      bus.DrawY = (i < n) ? 10'(py[i]) : 10'd0;
      @(negedge Clk);
      if (i >= 1 && i <= n)
        chk({tag, "_addr"}, 32'(bus.text_addr), ea[i-1]);
      if (i >= 3)
        chk({tag, "_pix"}, 32'(bus.pixel_on), ep[i-3]);
    end
    px.delete();
    py.delete();
  endtask

  task automatic pulse(input bit fs, input bit rs);
    @(posedge Clk);
    #1;
    bus.frame_start = fs;
    bus.restart = rs;
    @(posedge Clk);
    if (rs) begin
      m_rc = 0;
      m_fc = 0;
    end else if (fs && m_rc < NCH) begin
      if (m_fc == FPC - 1) begin
        m_fc = 0;
        m_rc++;
      end else begin
        m_fc++;
      end
    end
    #1;
    bus.frame_start = 1'b0;
    bus.restart = 1'b0;
    @(negedge Clk);
    chk("reveal_done", 32'(bus.reveal_done), 32'(m_rc == NCH));
    chk("reveal_count", 32'(dut.reveal_count), m_rc);
    chk("frame_cnt", 32'(dut.frame_cnt), m_fc);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      txt[i] = char_t'($urandom_range(127, 1));
    bus.frame_start = 1'b0;
    bus.restart = 1'b0;
    bus.DrawX = 10'd256;
    bus.DrawY = 10'd64;
    #1;
    chk("rst_pix", 32'(bus.pixel_on), 0);
    chk("rst_addr", 32'(bus.text_addr), 0);
    chk("rst_done", 32'(bus.reveal_done), 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int x = 250; x < 334; x++) add_pt(x, BY);
    run_pts("sweep");

    repeat (4) pulse(1'b1, 1'b0);
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < 8; b++) add_pt(BX + 8 + b, BY + r);
    for (int b = 0; b < 8; b++) add_pt(BX + 16 + b, BY + 5);
    for (int b = 0; b < 8; b++) add_pt(BX + b, BY + 9);
    run_pts("reveal");

    pulse(1'b0, 1'b1);
    repeat (18) pulse(1'b1, 1'b0);
    repeat (3) pulse(1'b1, 1'b0);

    for (int i = 0; i < 200; i++)
      add_pt(int'($urandom_range(340, 240)),
             int'($urandom_range(88, 56)));
    run_pts("rand");

    txt[3] = 7'd0;
    add_pt(255, BY + 4);
    add_pt(328, BY + 4);
    add_pt(BX + 5, 63);
    add_pt(BX + 5, 80);
    add_pt(0, 0);
    add_pt(1023, 1023);
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < 8; b++) add_pt(BX + 24 + b, BY + r);
    run_pts("bounds");

    pulse(1'b1, 1'b1);
    repeat (2) pulse(1'b1, 1'b0);

    @(posedge Clk);
    #1;
    bus.DrawX = 10'(BX + 2);
    bus.DrawY = 10'(BY + 3);
    repeat (4) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    m_rc = 0;
    m_fc = 0;
    #1;
    chk("arst_pix", 32'(bus.pixel_on), 0);
    chk("arst_addr", 32'(bus.text_addr), 0);
    chk("arst_done", 32'(bus.reveal_done), 0);
    chk("arst_count", 32'(dut.reveal_count), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("post_rst_pix", 32'(bus.pixel_on), 0);
    end
    chk("post_rst_done", 32'(bus.reveal_done), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
